// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, W-bit selector with an autonomous
// downward channel sweep. Manual mode presents A[sel] one cycle later;
// scan mode walks CHANNELS-1 down to 0, presenting each channel for
// DWELL cycles, freezing while hold is high.
//
// state | meaning
// IDLE  | manual select, or waiting for start when mode=1
// SCAN  | sweep engine running (busy)
// DONE  | one-cycle completion pulse, returns to IDLE
module scan_mux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      hold,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [SEL_W:0]   CH_NUM  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  ch;
  logic [DW_W-1:0]   dwell;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  scan_data;
  logic              sel_in_range;

  // Live data muxes for the manual select and for the scan channel.
  // Out-of-range selects (non-power-of-2 channel counts) yield zero.
  always_comb begin
    sel_data  = '0;
    scan_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) sel_data  = A[i*WIDTH +: WIDTH];
      if (ch  == SEL_W'(i)) scan_data = A[i*WIDTH +: WIDTH];
    end
  end

  assign sel_in_range = ({1'b0, sel} < CH_NUM);

  // Status flags decode straight from the state register.
  assign busy = (state == SCAN);
  assign done = (state == DONE);

  // Sequencer: state, sweep counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= '0;
      dwell   <= '0;
      Y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!mode) begin
            y_ch <= sel;
            if (sel_in_range) begin
              Y       <= sel_data;
              y_valid <= 1'b1;
            end else begin
              Y       <= '0;
              y_valid <= 1'b0;
            end
          end else begin
            y_valid <= 1'b0;
            if (start) begin
              state <= SCAN;
              ch    <= CH_LAST;
              dwell <= '0;
            end
          end
        end
        SCAN: begin
          if (hold) begin
            y_valid <= 1'b0;
          end else begin
            Y       <= scan_data;
            y_ch    <= ch;
            y_valid <= 1'b1;
            if (dwell == DW_LAST) begin
              dwell <= '0;
              // Channel 0 ends the sweep; the counter never wraps.
              if (ch == '0) state <= DONE;
              else          ch    <= ch - 1'b1;
            end else begin
              dwell <= dwell + 1'b1;
            end
          end
        end
        DONE: begin
          y_valid <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          y_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: default-parameter instance checked through a
// scoreboard queue, plus a WIDTH=8/CHANNELS=3/DWELL=1 instance checked
// with a short hand-written sequence.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [3:0] a_a;
  logic [1:0] sel_a;
  logic       mode_a, start_a, hold_a;
  logic [0:0] y_a;
  logic [1:0] ych_a;
  logic       vld_a, busy_a, done_a;

  scan_mux dut_a (
    .clk(clk), .rst_n(rst_n), .A(a_a), .sel(sel_a), .mode(mode_a),
    .start(start_a), .hold(hold_a), .Y(y_a), .y_ch(ych_a),
    .y_valid(vld_a), .busy(busy_a), .done(done_a)
  );

  // Instance B: WIDTH=8, CHANNELS=3, DWELL=1
  logic [23:0] a_b;
  logic [1:0]  sel_b;
  logic        mode_b, start_b, hold_b;
  logic [7:0]  y_b;
  logic [1:0]  ych_b;
  logic        vld_b, busy_b, done_b;

  scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .A(a_b), .sel(sel_b), .mode(mode_b),
    .start(start_b), .hold(hold_b), .Y(y_b), .y_ch(ych_b),
    .y_valid(vld_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic       y;
    logic [1:0] ch;
    logic       valid;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [1:0] sel;
    logic       exp_y;
  } vec_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  logic       last_y;
  logic [1:0] last_ch;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic y, input logic [1:0] ch, input logic v,
                      input logic b, input logic d);
    exp_t e;
    e.y = y; e.ch = ch; e.valid = v; e.busy = b; e.done = d;
    sbq.push_back(e);
    last_y  = y;
    last_ch = ch;
  endtask

  task automatic chk_q(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=none expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      cmp({tag, ".y"},     32'(y_a),    32'(e.y));
      cmp({tag, ".ch"},    32'(ych_a),  32'(e.ch));
      cmp({tag, ".valid"}, 32'(vld_a),  32'(e.valid));
      cmp({tag, ".busy"},  32'(busy_a), 32'(e.busy));
      cmp({tag, ".done"},  32'(done_a), 32'(e.done));
    end
  endtask

  task automatic chk_zero_a(input string tag);
    cmp({tag, ".y"},     32'(y_a),    32'd0);
    cmp({tag, ".ch"},    32'(ych_a),  32'd0);
    cmp({tag, ".valid"}, 32'(vld_a),  32'd0);
    cmp({tag, ".busy"},  32'(busy_a), 32'd0);
    cmp({tag, ".done"},  32'(done_a), 32'd0);
  endtask

  // Full sweep on instance A (4 channels, dwell 2). The valid sequence is
  // fixed by the schedule; hold cycles insert invalid samples that keep
  // the previous Y/y_ch.
  task automatic scan_a(input string tag, input logic [3:0] a, input int hold_at,
                        input int hold_len, input bit toggles);
    logic       vy[8];
    logic [1:0] vch[8];
    int idx;
    int cyc;
    bit hnow;
    for (int j = 0; j < 8; j++) begin
      vch[j] = 2'(3 - j / 2);
      vy[j]  = a[3 - j / 2];
    end
    a_a = a; mode_a = 1'b1; start_a = 1'b1; hold_a = 1'b0;
    push(last_y, last_ch, 1'b0, 1'b1, 1'b0);
    step();
    chk_q({tag, ".start"});
    start_a = 1'b0;
    idx = 0;
    cyc = 1;
    while (idx < 8 && cyc < 40) begin
      hnow = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      hold_a = hnow;
      if (toggles) begin
        start_a = cyc[0];
        mode_a  = cyc[1];
      end
      if (hnow) begin
        push(last_y, last_ch, 1'b0, 1'b1, 1'b0);
      end else begin
        push(vy[idx], vch[idx], 1'b1, (idx < 7), (idx == 7));
        idx++;
      end
      step();
      chk_q($sformatf("%s.c%0d", tag, cyc));
      cyc++;
    end
    // start during the DONE cycle must be ignored
    hold_a = 1'b0; mode_a = 1'b1; start_a = 1'b1;
    push(last_y, last_ch, 1'b0, 1'b0, 1'b0);
    step();
    chk_q({tag, ".done_exit"});
    start_a = 1'b0;
    push(last_y, last_ch, 1'b0, 1'b0, 1'b0);
    step();
    chk_q({tag, ".idle"});
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: 4'b1010, sel: 2'd3, exp_y: 1'b1};
    vecs[1] = '{a: 4'b1010, sel: 2'd2, exp_y: 1'b0};
    vecs[2] = '{a: 4'b1010, sel: 2'd1, exp_y: 1'b1};
    vecs[3] = '{a: 4'b1010, sel: 2'd0, exp_y: 1'b0};
    vecs[4] = '{a: 4'b0101, sel: 2'd0, exp_y: 1'b1};
    vecs[5] = '{a: 4'b0101, sel: 2'd3, exp_y: 1'b0};
    vecs[6] = '{a: 4'b1111, sel: 2'd2, exp_y: 1'b1};

    rst_n   = 1'b0;
    a_a     = 4'($urandom);
    sel_a   = 2'($urandom);
    mode_a  = 1'b0; start_a = 1'b0; hold_a = 1'b0;
    a_b     = 24'($urandom);
    sel_b   = 2'd0;
    mode_b  = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    #12;
    chk_zero_a("rst_init");

    @(negedge clk);
    rst_n = 1'b1;

    // make outputs nonzero, then reset between edges
    a_a = 4'b1111; sel_a = 2'd2; mode_a = 1'b0;
    step();
    cmp("pre_rst.valid", 32'(vld_a), 32'd1);
    #2;
    a_a = 4'($urandom); sel_a = 2'($urandom);
    rst_n = 1'b0;
    #1;
    chk_zero_a("rst_async");
    @(negedge clk);
    rst_n = 1'b1;

    // manual mode table
    mode_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_a   = vecs[i].a;
      sel_a = vecs[i].sel;
      push(vecs[i].exp_y, vecs[i].sel, 1'b1, 1'b0, 1'b0);
      step();
      chk_q($sformatf("man%0d", i));
    end

    scan_a("scan", 4'b0011, 100, 0, 1'b0);
    scan_a("hold", 4'b0110, 4, 3, 1'b1);

    // reset in the middle of a sweep
    a_a = 4'b0011; mode_a = 1'b1; start_a = 1'b1; hold_a = 1'b0;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 12 && !(vld_a && ych_a == 2'd1); i++) step();
    cmp("midscan.reach_ch1", 32'(ych_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_a("rst_midscan");
    @(negedge clk);
    rst_n = 1'b1;
    last_y = 1'b0; last_ch = 2'd0;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk_q($sformatf("post_rst%0d", i));
    end

    // instance B: 3 channels of 8 bits, dwell 1
    a_b = {8'hC3, 8'h5A, 8'h01};
    mode_b = 1'b0; sel_b = 2'd3;
    step();
    cmp("b_sel3.y",     32'(y_b),   32'h00);
    cmp("b_sel3.valid", 32'(vld_b), 32'd0);
    cmp("b_sel3.ch",    32'(ych_b), 32'd3);
    sel_b = 2'd1;
    step();
    cmp("b_sel1.y",     32'(y_b),   32'h5A);
    cmp("b_sel1.valid", 32'(vld_b), 32'd1);
    mode_b = 1'b1; start_b = 1'b1;
    step();
    cmp("b_start.busy",  32'(busy_b), 32'd1);
    cmp("b_start.valid", 32'(vld_b),  32'd0);
    start_b = 1'b0;
    step();
    cmp("b_s0.y",    32'(y_b),    32'hC3);
    cmp("b_s0.ch",   32'(ych_b),  32'd2);
    cmp("b_s0.busy", 32'(busy_b), 32'd1);
    step();
    cmp("b_s1.y",    32'(y_b),    32'h5A);
    cmp("b_s1.ch",   32'(ych_b),  32'd1);
    cmp("b_s1.done", 32'(done_b), 32'd0);
    step();
    cmp("b_s2.y",     32'(y_b),    32'h01);
    cmp("b_s2.valid", 32'(vld_b),  32'd1);
    cmp("b_s2.done",  32'(done_b), 32'd1);
    cmp("b_s2.busy",  32'(busy_b), 32'd0);
    step();
    cmp("b_end.valid", 32'(vld_b),  32'd0);
    cmp("b_end.done",  32'(done_b), 32'd0);
    cmp("b_end.y",     32'(y_b),    32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
